// File: rtl/sar_result_fifo.sv
// SAR result capture: sync + falling-edge detect on compl, bit-reversed capture, result FIFO.
// Optional averaging of 2**AVG_LOG2 raw samples per pushed word when SAR_RES_AVG_EN is defined.
module sar_result_fifo #(
  parameter int ADC_BITS   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AVG_LOG2   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          compl,
  input  logic [0:ADC_BITS-1]           adc_data,
  output logic [ADC_BITS-1:0]           dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [15:0]                   sample_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef logic [ADC_BITS-1:0] word_t;

  logic        sync1_q;
  logic        compl_s_q;
  logic        compl_d_q;
  logic        cap;
  word_t       rev;
  logic        push;
  word_t       push_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b0;
      compl_s_q <= 1'b0;
      compl_d_q <= 1'b0;
    end else begin
      sync1_q   <= compl;
      compl_s_q <= sync1_q;
      compl_d_q <= compl_s_q;
    end
  end

  // SAR publishes its result as compl drops
  assign cap = compl_d_q & ~compl_s_q;

  always_comb begin
    rev = '0;
    for (int k = 0; k < ADC_BITS; k++) begin
      rev[ADC_BITS-1-k] = adc_data[k];
    end
  end

`ifdef SAR_RES_AVG_EN
  localparam int AW = ADC_BITS + AVG_LOG2;

  logic [AW-1:0]       acc_q;
  logic [AW-1:0]       acc_d;
  logic [AW-1:0]       acc_sum;
  logic [AVG_LOG2-1:0] avg_cnt_q;
  logic [AVG_LOG2-1:0] avg_cnt_d;

  assign acc_sum = acc_q + AW'(rev);

  always_comb begin
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    push      = 1'b0;
    push_word = acc_sum[AW-1:AVG_LOG2];
    if (cap) begin
      if (&avg_cnt_q) begin
        push      = 1'b1;
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  assign push      = cap;
  assign push_word = rev;
`endif

  word_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  rd_nxt;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  word_t          dout_q;
  word_t          dout_d;
  logic           ovf_q;
  logic           ovf_d;
  logic [15:0]    cnt_q;
  logic           empty;
  logic           full;
  logic           pop;
  logic           wr_en;
  logic           drop;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign pop    = ~empty & dout_ready;
  assign wr_en  = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign rd_nxt = rd_ptr_q + 1'b1;

  always_comb begin
    dout_d = dout_q;
    if (pop) begin
      if (level_q > LW'(1)) begin
        dout_d = mem_q[rd_nxt];
      end else if (wr_en) begin
        dout_d = push_word;
      end
    end else if (empty && wr_en) begin
      dout_d = push_word;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // a fresh overflow beats a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_nxt;
      level_q <= level_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_q + 16'(cap);
    end
  end

  assign dout       = dout_q;
  assign dout_valid = ~empty;
  assign ovf        = ovf_q;
  assign level      = level_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sar_result_fifo.sv
// Bench for sar_result_fifo: queue-based model plus directed and jittered conversions.
// Define SAR_RES_AVG_EN on both files to run the averaging scenario.
module tb_sar_result_fifo;
  localparam int AB    = 8;
  localparam int DEPTH = 4;
  localparam int AVGL  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            compl = 1'b0;
  logic            dout_ready = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [0:AB-1]   adc_data = '0;
  logic [AB-1:0]   dout;
  logic            dout_valid;
  logic            ovf;
  logic [2:0]      level;
  logic [15:0]     sample_cnt;

  always #5 clk = ~clk;

  sar_result_fifo #(.ADC_BITS(AB), .FIFO_DEPTH(DEPTH), .AVG_LOG2(AVGL)) dut (
    .clk(clk), .rst(rst), .compl(compl), .adc_data(adc_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .ovf(ovf), .ovf_clr(ovf_clr), .level(level), .sample_cnt(sample_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // dout-order value -> SAR-order vector
  function automatic logic [0:AB-1] to_adc(input logic [AB-1:0] v);
    logic [0:AB-1] a;
    for (int k = 0; k < AB; k++) a[k] = v[AB-1-k];
    return a;
  endfunction

  // model: captures land on the 3rd rising edge after compl drops
  int            cyc = 0;
  int            due_q[$];
  logic [AB-1:0] val_q[$];
  logic [AB-1:0] mq[$];
  bit            m_ovf = 0;
  int            m_cnt = 0;
  int            m_acc = 0;
  int            m_n = 0;
  bit            chk_en = 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete(); due_q.delete(); val_q.delete();
      m_ovf = 0; m_cnt = 0; m_acc = 0; m_n = 0;
    end else begin : step
      bit            pop;
      bit            push;
      bit            room;
      logic [AB-1:0] w;
      cyc++;
      pop  = dout_ready && (mq.size() > 0);
      room = (mq.size() < DEPTH) || pop;
      push = 0;
      w    = '0;
      if (ovf_clr) m_ovf = 0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        w = val_q.pop_front();
        m_cnt = (m_cnt + 1) % 65536;
`ifdef SAR_RES_AVG_EN
        m_acc += w;
        m_n++;
        if (m_n == (1 << AVGL)) begin
          w = AB'(m_acc / (1 << AVGL));
          push = 1; m_acc = 0; m_n = 0;
        end
`else
        push = 1;
`endif
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (room) mq.push_back(w);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("level", level, mq.size());
      chk("valid", dout_valid, mq.size() != 0);
      if (mq.size() != 0) chk("dout", dout, mq[0]);
      chk("ovf", ovf, m_ovf);
      chk("sample_cnt", sample_cnt, m_cnt);
    end
  end

  // mode: 0 plain, 1 consumer ready on capture edge, 2 ovf_clr on capture edge
  task automatic conv(input logic [AB-1:0] v, input int mode);
    @(negedge clk);
    adc_data = to_adc(v);
    compl = 1'b1;
    repeat (2) @(negedge clk);
    compl = 1'b0;
    due_q.push_back(cyc + 3);
    val_q.push_back(v);
    if (mode != 0) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      if (mode == 1) dout_ready = 1'b1;
      else ovf_clr = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    dout_ready = 1'b0; ovf_clr = 1'b0; compl = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    @(negedge clk);
    dout_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    dout_ready = 1'b0;
  endtask

  bit            t5_on = 0;
  logic [AB-1:0] sent[$];
  int            rx = 0;

  always @(negedge clk) begin
    if (t5_on && rst && dout_valid && dout_ready) begin
      if (rx < sent.size()) chk("t5_word", dout, sent[rx]);
      else chk("t5_extra", rx, sent.size());
      rx++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at %0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cnt", sample_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

`ifndef SAR_RES_AVG_EN
    // T2: only the last SAR-order bit set lands in dout bit 0
    conv(8'h01, 0);
    chk("t2_dout", dout, 8'h01);
    chk("t2_valid", dout_valid, 1);
    conv(8'h80, 0);
    chk("t2_lvl", level, 2);
    drain();

    // T3: back-pressure and overflow
    do_reset();
    for (int i = 1; i <= 5; i++) conv(AB'(8'h11 * i), 0);
    @(negedge clk);
    chk("t3_level", level, 4);
    chk("t3_ovf", ovf, 1);
    chk("t3_cnt", sample_cnt, 5);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t3_drain", dout, AB'(8'h11 * i));
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
    end
    chk("t3_empty", dout_valid, 0);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", ovf, 0);

    // T4: push and pop on a full FIFO
    do_reset();
    for (int i = 1; i <= 4; i++) conv(AB'(8'h11 * i), 0);
    conv(8'h55, 1);
    chk("t4_level", level, 4);
    chk("t4_ovf", ovf, 0);
    chk("t4_head", dout, 8'h22);
    conv(8'h66, 2);
    chk("t4_clr_vs_ovf", ovf, 1);
    drain();

    // T1: asynchronous reset with data queued
    conv(8'hA5, 0);
    conv(8'h5A, 0);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t1_dout", dout, 0);
    chk("t1_valid", dout_valid, 0);
    chk("t1_level", level, 0);
    chk("t1_cnt", sample_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_rel_level", level, 0);
    chk("t1_rel_ovf", ovf, 0);

    // T5: jittered conversions, consumer always ready
    do_reset();
    chk_en = 0;
    dout_ready = 1'b1;
    t5_on = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [AB-1:0] v;
      v = AB'($urandom);
      sent.push_back(v);
      #($urandom_range(1, 9));
      adc_data = to_adc(v);
      compl = 1'b1;
      #($urandom_range(25, 40));
      compl = 1'b0;
      #($urandom_range(50, 60));
    end
    repeat (10) @(negedge clk);
    t5_on = 0;
    chk("t5_rx", rx, 1000);
    chk("t5_cnt", sample_cnt, 1000);
    chk("t5_ovf", ovf, 0);
    dout_ready = 1'b0;
`else
    // T6: four raw samples averaged into one word
    do_reset();
    conv(8'h10, 0);
    conv(8'h20, 0);
    conv(8'h30, 0);
    chk("t6_none", dout_valid, 0);
    conv(8'h41, 0);
    chk("t6_dout", dout, 8'h28);
    chk("t6_valid", dout_valid, 1);
    chk("t6_level", level, 1);
    chk("t6_cnt", sample_cnt, 4);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
